// File: rtl/game_event_scheduler.sv
// game_event_scheduler
//
// Purpose:
//   A bank of NUM_CH independent game-event timers. Each channel is
//   programmed with a period measured in gameTime ticks and then either
//   fires once (one-shot) or keeps firing every period (periodic). Firing
//   produces a one-cycle eventPulse and sets a sticky pending flag. A fire
//   that lands while pending is still set also sets a sticky overrun flag.
//   Deadlines are compared wrap-safely, so timers keep working when
//   gameTime rolls over 2^32.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous active-high reset
//   gameTime    free-running 32-bit game cycle count
//   cfgWr       one-cycle strobe that programs channel cfgCh
//   cfgCh       channel index for cfgWr (out-of-range writes are ignored)
//   cfgPeriod   period in gameTime ticks, 0 disarms the channel
//   cfgOneShot  1 = fire once then idle, 0 = periodic
//   ack         per-channel clear of pending and overrun
//   eventPulse  per-channel one-cycle firing pulse (registered)
//   pending     per-channel sticky "has fired" flag (registered)
//   overrun     per-channel sticky "fired again before ack" flag (registered)
//   armed       per-channel 1 while the timer is running (registered)

module game_event_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 24,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         gameTime,
  input  logic                cfgWr,
  input  logic [CH_W-1:0]     cfgCh,
  input  logic [PERIOD_W-1:0] cfgPeriod,
  input  logic                cfgOneShot,
  input  logic [NUM_CH-1:0]   ack,
  output logic [NUM_CH-1:0]   eventPulse,
  output logic [NUM_CH-1:0]   pending,
  output logic [NUM_CH-1:0]   overrun,
  output logic [NUM_CH-1:0]   armed
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } chState_e;

  chState_e            state_q    [NUM_CH];
  chState_e            state_d    [NUM_CH];
  logic [31:0]         deadline_q [NUM_CH];
  logic [31:0]         deadline_d [NUM_CH];
  logic [PERIOD_W-1:0] period_q   [NUM_CH];
  logic [PERIOD_W-1:0] period_d   [NUM_CH];
  logic [NUM_CH-1:0]   oneShot_q;
  logic [NUM_CH-1:0]   oneShot_d;
  logic [NUM_CH-1:0]   pulse_q;
  logic [NUM_CH-1:0]   pulse_d;
  logic [NUM_CH-1:0]   pending_q;
  logic [NUM_CH-1:0]   pending_d;
  logic [NUM_CH-1:0]   overrun_q;
  logic [NUM_CH-1:0]   overrun_d;

  logic [31:0]         timeDiff   [NUM_CH];
  logic [NUM_CH-1:0]   cfgHit;
  logic [NUM_CH-1:0]   due;
  logic                cfgInRange;
  logic [31:0]         cfgPeriodExt;

  // A write to a channel index beyond NUM_CH must not touch any channel.
  assign cfgInRange   = (32'(cfgCh) < 32'(NUM_CH));
  assign cfgPeriodExt = 32'(cfgPeriod);

  // Per-channel decode of the config strobe and the fire condition.
  // The fire test uses the sign bit of (gameTime - deadline) so that a
  // deadline just past the 2^32 wrap is still seen as "in the future".
  always_comb begin
    cfgHit = '0;
    due    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      timeDiff[i] = gameTime - deadline_q[i];
      cfgHit[i]   = cfgWr && cfgInRange && (cfgCh == CH_W'(i));
      due[i]      = (state_q[i] == ARMED) && !timeDiff[i][31];
    end
  end

  // Next-state logic. Priority per channel: a config write beats a fire
  // (the old deadline is simply discarded), and a fire beats ack so that a
  // firing is never lost. A periodic re-arm adds the period to the old
  // deadline rather than to gameTime, so late service never causes drift.
  always_comb begin
    pulse_d   = '0;
    pending_d = pending_q;
    overrun_d = overrun_q;
    oneShot_d = oneShot_q;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]    = state_q[i];
      deadline_d[i] = deadline_q[i];
      period_d[i]   = period_q[i];

      if (cfgHit[i]) begin
        if (cfgPeriod != '0) begin
          state_d[i]    = ARMED;
          period_d[i]   = cfgPeriod;
          oneShot_d[i]  = cfgOneShot;
          deadline_d[i] = gameTime + cfgPeriodExt;
        end else begin
          state_d[i] = IDLE;
        end
        if (ack[i]) begin
          pending_d[i] = 1'b0;
          overrun_d[i] = 1'b0;
        end
      end else if (due[i]) begin
        pulse_d[i]    = 1'b1;
        pending_d[i]  = 1'b1;
        overrun_d[i]  = ack[i] ? 1'b0 : (overrun_q[i] | pending_q[i]);
        deadline_d[i] = deadline_q[i] + 32'(period_q[i]);
        if (oneShot_q[i]) begin
          state_d[i] = IDLE;
        end
      end else if (ack[i]) begin
        pending_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  // State register; reset wipes every channel back to an idle, zeroed timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= IDLE;
        deadline_q[i] <= '0;
        period_q[i]   <= '0;
      end
      oneShot_q <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= state_d[i];
        deadline_q[i] <= deadline_d[i];
        period_q[i]   <= period_d[i];
      end
      oneShot_q <= oneShot_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // All outputs come straight from flops.
  always_comb begin
    armed = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      armed[i] = (state_q[i] == ARMED);
    end
  end

  assign eventPulse = pulse_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/game_event_scheduler.md
GAME_EVENT_SCHEDULER -- requirements
Module: game_event_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent event channels.
REQ-002 SHALL have parameter PERIOD_W, default 24, width of programmed period.
REQ-003 SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 gameTime  input  32  free-running game cycle count from the game clock, incrementing by 1 per clk and wrapping at 2^32.
REQ-007 cfgWr  input  1  one-cycle strobe that programs channel cfgCh.
REQ-008 cfgCh  input  log2(NUM_CH)  channel selected by cfgWr.
REQ-009 cfgPeriod  input  PERIOD_W  period in gameTime ticks; 0 means disarm.
REQ-010 cfgOneShot  input  1  1 = fire once then idle; 0 = periodic.
REQ-011 ack  input  NUM_CH  per-channel clear of pending and overrun.
REQ-012 eventPulse  output  NUM_CH  one-cycle pulse per firing.
REQ-013 pending  output  NUM_CH  sticky flag, set on fire, cleared by ack.
REQ-014 overrun  output  NUM_CH  sticky flag, set when a channel fires while its pending is already 1.
REQ-015 armed  output  NUM_CH  1 while the channel is in ARMED.

Function
REQ-016 Each channel SHALL hold the following state: IDLE/ARMED, a 32-bit deadline, a PERIOD_W period, and a oneShot bit.
REQ-017 When cfgWr is asserted with cfgPeriod != 0 in the cycle gameTime = G, the selected channel SHALL latch period P, latch oneShot, set deadline = G + P (mod 2^32), and enter ARMED at the next edge, from either IDLE or ARMED.
REQ-018 When cfgWr is asserted with cfgPeriod = 0, the selected channel SHALL enter IDLE; pending and overrun SHALL be unchanged.
REQ-019 Reprogramming an ARMED channel SHALL discard the old deadline; pending and overrun SHALL be unchanged.
REQ-020 Fire condition: the channel is ARMED and bit 31 of (gameTime - deadline) is 0, i.e. a wrap-safe signed comparison "gameTime >= deadline".
REQ-021 In a cycle where the fire condition holds, the channel SHALL drive eventPulse[i] = 1 after the next edge for exactly one cycle.
REQ-022 Fire latency: with P = N, eventPulse SHALL be high in the cycle after gameTime = G + N is sampled.
REQ-023 On a periodic fire, the channel SHALL set deadline = deadline + P, not gameTime + P (no drift), and SHALL remain ARMED.
REQ-024 On a one-shot fire, the channel SHALL enter IDLE.
REQ-025 On any fire, pending[i] SHALL be set; if pending[i] was already 1 and ack[i] = 0, overrun[i] SHALL be set as well.
REQ-026 ack[i] SHALL clear pending[i] and overrun[i] at the next edge.
REQ-027 If ack[i] and a fire occur in the same cycle, the fire SHALL win: pending[i] = 1 and overrun[i] = 0.
REQ-028 If cfgWr for channel i coincides with a fire on channel i, the cfgWr SHALL win: no eventPulse and no pending change.
REQ-029 Channels SHALL be fully independent; any subset MAY fire in the same cycle.
REQ-030 With P = 1, a periodic channel SHALL fire every cycle.
REQ-031 A deadline wrapping past 2^32 SHALL fire correctly at the wrapped gameTime value.
REQ-032 cfgWr with cfgCh >= NUM_CH SHALL be ignored.
REQ-033 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-034 While reset = 1 at an edge, every channel SHALL become IDLE, and eventPulse, pending, overrun and armed SHALL be 0.
REQ-035 Internal deadline and period SHALL be cleared to 0.
REQ-036 Reset SHALL override cfgWr, ack and any fire in the same cycle.
REQ-037 Reset asserted mid-period SHALL cancel the channel; no eventPulse SHALL occur after reset deasserts until the channel is reprogrammed.

Verification
REQ-038 Periodic timing: program ch0 with P = 5, periodic, at gameTime = 100 -> eventPulse[0] high in the cycles after gameTime 105, 110 and 115; pending[0] = 1; overrun[0] = 1 from the second fire on, with no ack given.
REQ-039 One-shot and ack: program ch1 with P = 3, one-shot, at gameTime = 20 -> a single pulse after gameTime 23, after which armed[1] = 0; asserting ack[1] at gameTime 30 clears pending[1].
REQ-040 Wrap-around: program ch2 with P = 10 at gameTime = 0xFFFFFFFA -> the pulse follows gameTime = 0x00000004, with no early fire near 0xFFFFFFFF.
REQ-041 Collisions: assert ack[0] in a fire cycle -> pending[0] stays 1 and overrun[0] = 0; assert cfgWr on a channel in its fire cycle -> no pulse, and a new deadline of G + P.
REQ-042 Disarm and reset: cfgPeriod = 0 on an armed channel -> no further pulses with pending retained; reset mid-period -> all outputs 0 and no later pulses.
REQ-043 Concurrency: all 4 channels with P = 1, 2, 3, 4 from the same G -> all four pulse together after G + 12, and each channel's pulse count over 24 cycles equals 24/P.
